// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// requester port indices and the round-robin distance helper.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACCESS = 3'b010,
    ST_RESP   = 3'b100
  } state_t;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;
  localparam int PORT_LOAD  = 2;

  // Search distance of port idx when the search starts just after port last.
  function automatic int rr_dist(input int idx, input int last, input int np);
    return (idx + np - 1 - last) % np;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: the requesting port closest after the
// last-served pointer wins; returns a one-hot winner and a valid flag.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NP = 3,
  parameter int LW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic [NP-1:0] i_req,
  input  logic [LW-1:0] i_last,
  output logic [NP-1:0] o_grant,
  output logic          o_valid
);

  int w_best;

  always_comb begin
    w_best = NP;
    for (int i = 0; i < NP; i++) begin
      if (i_req[i] && (rr_dist(i, int'(i_last), NP) < w_best)) begin
        w_best = rr_dist(i, int'(i_last), NP);
      end
    end
    o_grant = '0;
    for (int i = 0; i < NP; i++) begin
      o_grant[i] = i_req[i] && (rr_dist(i, int'(i_last), NP) == w_best);
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous memory
// between NP requesters with a req/ack handshake.
//
// state  | meaning
// IDLE   | no access in flight, arbitrating every cycle
// ACCESS | memory driven from the latched grant
// RESP   | ack + rdata to the owner, re-arbitrate among the other ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NP = 3,
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NP-1:0]    req,
  input  logic [NP-1:0]    we,
  input  logic [NP*AW-1:0] addr,
  input  logic [NP*DW-1:0] wdata,
  output logic [NP-1:0]    ack,
  output logic [DW-1:0]    rdata,
  output logic [NP-1:0]    grant,
  output logic             busy,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int LW = (NP > 1) ? $clog2(NP) : 1;

  state_t        r_state;
  logic [NP-1:0] r_grant;
  logic [LW-1:0] r_last;

  logic [NP-1:0] w_mask;
  logic [NP-1:0] w_pick;
  logic          w_valid;
  logic [LW-1:0] w_gidx;
  logic [LW-1:0] w_last_sel;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  always_comb begin
    w_gidx      = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NP; i++) begin
      if (r_grant[i]) begin
        w_gidx      = LW'(i);
        w_sel_we    = we[i];
        w_sel_addr  = addr[i*AW +: AW];
        w_sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // In RESP the owner still holds req during its ack cycle, so it is masked
  // and the search starts after it as if last had already moved.
  assign w_mask     = (r_state == ST_RESP) ? (req & ~r_grant) : req;
  assign w_last_sel = (r_state == ST_RESP) ? w_gidx : r_last;

  rr_picker #(.NP(NP), .LW(LW)) u_picker (
    .i_req   (w_mask),
    .i_last  (w_last_sel),
    .o_grant (w_pick),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LW'(NP - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant <= w_pick;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: r_state <= ST_RESP;
        ST_RESP: begin
          r_last <= w_gidx;
          if (w_valid) begin
            r_grant <= w_pick;
            r_state <= ST_ACCESS;
          end else begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ack       = '0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    grant     = r_grant;
    busy      = (r_state == ST_ACCESS) || (r_state == ST_RESP);
    if (r_state == ST_ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = w_sel_we;
      mem_addr  = w_sel_addr;
      mem_wdata = w_sel_wdata;
    end
    if (r_state == ST_RESP) begin
      ack   = r_grant;
      rdata = mem_rdata;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer for the CPU's single-port synchronous memory. It shares one memory between up to NP requesters: port 0 is instruction fetch, port 1 is data load/store, and port 2 is the debug/program loader. Each access goes through a req/ack handshake, and the block drives the memory's enable, write, address and data lines. It sits between the CONTROL-driven fetch/data paths and the memory macro.

## Interface
Parameters:
- NP, 3, number of requesters (≥2)
- AW, 5, address width
- DW, 8, data width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NP  per-port request; held high until that port's ack
- we  in  NP  per-port write flag (1 = store), sampled with req
- addr  in  NP*AW  flattened per-port addresses; port i at [i*AW +: AW]
- wdata  in  NP*DW  flattened per-port write data
- ack  out  NP  one-hot, single-cycle completion pulse
- rdata  out  DW  read data, valid in the ack cycle of a read
- grant  out  NP  one-hot owner of the current access, 0 when idle
- busy  out  1  high in ACCESS and RESP
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; registered by the memory, valid one cycle after mem_en

## Operation
- FSM states, encoded as a one-hot enum:
  - IDLE
  - ACCESS
  - RESP
- **IDLE**:
  - If any req is high, pick a winner round-robin, latch it into grant_q and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**: drive the winner's access to memory.
  - mem_en=1
  - mem_we=we[g]
  - mem_addr=addr[g]
  - mem_wdata=wdata[g]
  - All selected from the latched grant.
- **RESP**:
  - ack[g]=1 and rdata=mem_rdata. rdata is driven even for writes; the requester ignores it.
  - Last-served pointer updates to g.
  - If any req other than port g is high, re-arbitrate, latch the new winner and go straight to ACCESS.
  - Otherwise go to IDLE. Port g is masked because its req is still high in its ack cycle.
- **Round-robin rule**:
  - Search starts at last+1 and wraps from NP-1 to 0.
  - The first port with req high wins.
  - last resets to NP-1, so port 0 has first priority after reset.
- **Request rules**:
  - A requester deasserts req the cycle after its ack, or re-raises it for a new access.
  - If req drops during ACCESS, the access still completes and ack still pulses. No abort.
- **Reset**: rst_n low asynchronously forces:
  - state=IDLE, grant=0, last=NP-1
  - ack=0, mem_en=0, mem_we=0, busy=0
- **Reset mid-operation**:
  - An in-flight write may or may not have reached memory.
  - No ack is ever issued for it.
- Outside ACCESS: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.

## Timing
- req high in cycle N, bus idle:
  - ACCESS in N+1, ack in N+2.
  - Req-to-ack latency is 2 cycles.
- Sustained throughput is one access per 2 cycles when another port is waiting (RESP→ACCESS).
- A port that re-requests immediately is served again only after every other pending port has been served. Worst-case wait is 2*(NP-1) cycles after the current access.
- Simultaneous requests in IDLE resolve in the same cycle. There is no idle bubble.
- All outputs are combinational from registered state (state, grant_q). There is no combinational path from req to any memory signal.

## Structure
- Package mem_arb_pkg holds:
  - the state enum typedef (IDLE/ACCESS/RESP)
  - the port-index constants PORT_FETCH=0, PORT_DATA=1, PORT_LOAD=2
- Sub-module rr_picker: purely combinational.
  - Inputs: req mask and last pointer.
  - Outputs: one-hot winner and a valid flag.
  - Instantiated once; used in both IDLE and RESP.

## Test plan
- Reset then single read: mem preloaded addr 5=8'hA3; port 0 req, we=0, addr=5.
  - mem_en in cycle 1.
  - ack[0] and rdata=8'hA3 in cycle 2.
  - busy low in cycle 3.
- Write-then-read: port 1 writes 8'h5C to addr 31, then port 1 reads addr 31.
  - Second ack returns 8'h5C.
- All three req held from the same cycle: grants in order 0,1,2,0,1,2.
  - acks 2 cycles apart.
  - No IDLE cycles between them.
- Fairness: port 0 re-requests immediately after every ack while port 2 requests once.
  - Port 2 is acked no later than the second access after its req.
- Reset mid-operation: assert rst_n low during an ACCESS write by port 2.
  - grant, mem_en and ack go to 0 immediately.
  - After release, the first port-0 request is served before port 2's.
- req drop: port 1 drops req during ACCESS.
  - ack[1] still pulses in the following cycle.
  - FSM returns to IDLE.
